// File: rtl/lane_matmul_engine.sv
// lane_matmul_engine
//   Fixed-point GEMM: C = A*B, or C = C + A*B in accumulate mode. LANES
//   output columns of C are computed in parallel, one k step per cycle.
//   Results are optionally rounded (half-up), scaled by 2^-FRAC_WIDTH,
//   saturated to DATA_WIDTH with a sticky flag, and drained over a
//   ready/valid indexed stream in row-major order.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, acc_mode   : run request (IDLE only) and accumulate select
//   a_* / b_*         : indexed element writes for A (MxK) and B (KxN)
//   c_data/row/col    : result element and its index, valid on c_valid
//   c_valid, c_ready  : output handshake; c_* held while stalled
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   sat_flag          : sticky saturation indicator for the current run
module lane_matmul_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int M          = 64,
  parameter int N          = 64,
  parameter int K          = 64,
  parameter int LANES      = 4,
  parameter int ROUND      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    acc_mode,
  input  logic [DATA_WIDTH-1:0]   a_data,
  input  logic [$clog2(M)-1:0]    a_row,
  input  logic [$clog2(K)-1:0]    a_col,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  input  logic [$clog2(K)-1:0]    b_row,
  input  logic [$clog2(N)-1:0]    b_col,
  input  logic                    b_valid,
  output logic [DATA_WIDTH-1:0]   c_data,
  output logic [$clog2(M)-1:0]    c_row,
  output logic [$clog2(N)-1:0]    c_col,
  output logic                    c_valid,
  input  logic                    c_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag
);
  localparam int MW     = $clog2(M);
  localparam int KW     = $clog2(K);
  localparam int NW     = $clog2(N);
  localparam int GROUPS = N / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int AW     = 2 * DATA_WIDTH + $clog2(K);
  localparam int A_TOT  = M * K;
  localparam int B_TOT  = K * N;
  localparam int ACW    = $clog2(A_TOT + 1);
  localparam int BCW    = $clog2(B_TOT + 1);

  // Saturation bounds, sign-extended to the post-scale width.
  localparam logic signed [AW:0] SAT_MAX = {{(AW - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic signed [AW-1:0] RND_ADD = (ROUND != 0) ? AW'(2 ** (FRAC_WIDTH - 1)) : '0;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t                  state;
  logic [ACW-1:0]          a_count;
  logic [BCW-1:0]          b_count;
  logic                    acc_en;     // acc_mode as latched, gated by c_init
  logic                    c_init;     // C holds a completed result
  logic [MW-1:0]           r_idx;
  logic [GW-1:0]           g_idx;
  logic [KW-1:0]           k_idx;

  logic signed [DATA_WIDTH-1:0] a_mem [M][K];
  logic signed [DATA_WIDTH-1:0] b_mem [K][N];
  logic signed [DATA_WIDTH-1:0] c_mem [M][N];
  logic signed [AW-1:0]         acc   [LANES];

  // Load acceptance: writes stop counting once the matrix is full.
  logic                    a_take, b_take;
  logic [ACW-1:0]          a_count_n;
  logic [BCW-1:0]          b_count_n;
  assign a_take    = (state == LOAD) && a_valid && (a_count != ACW'(A_TOT));
  assign b_take    = (state == LOAD) && b_valid && (b_count != BCW'(B_TOT));
  assign a_count_n = a_count + ACW'(a_take);
  assign b_count_n = b_count + BCW'(b_take);

  logic                    last_k;
  assign last_k = (k_idx == KW'(K - 1));

  // Per-lane datapath: MAC, then finalisation of the K-long dot product.
  logic [NW-1:0]                lane_col [LANES];
  logic signed [AW-1:0]         sum      [LANES];
  logic signed [DATA_WIDTH-1:0] res      [LANES];
  logic [LANES-1:0]             clamp;
  logic signed [AW-1:0]         prod, rnd, shifted;
  logic signed [AW:0]           ext;

  // NOTE: every always_comb output gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    clamp   = '0;
    prod    = '0;
    rnd     = '0;
    shifted = '0;
    ext     = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_col[j] = NW'(int'(g_idx) * LANES + j);
      prod        = AW'(a_mem[r_idx][k_idx]) * AW'(b_mem[k_idx][lane_col[j]]);
      // k == 0 starts a fresh dot product, so stale accumulator is ignored.
      sum[j]      = ((k_idx == '0) ? '0 : acc[j]) + prod;
      rnd         = sum[j] + RND_ADD;
      shifted     = rnd >>> FRAC_WIDTH;
      ext         = (AW + 1)'(shifted) + (acc_en ? (AW + 1)'(c_mem[r_idx][lane_col[j]]) : '0);
      if (ext > SAT_MAX) begin
        res[j]   = SAT_MAX[DATA_WIDTH-1:0];
        clamp[j] = 1'b1;
      end else if (ext < SAT_MIN) begin
        res[j]   = SAT_MIN[DATA_WIDTH-1:0];
        clamp[j] = 1'b1;
      end else begin
        res[j]   = ext[DATA_WIDTH-1:0];
      end
    end
  end

  // Row-major successor of the element currently presented.
  logic [MW-1:0] next_row;
  logic [NW-1:0] next_col;
  always_comb begin
    next_row = c_row;
    next_col = c_col + NW'(1);
    if (c_col == NW'(N - 1)) begin
      next_col = '0;
      next_row = c_row + MW'(1);
    end
  end

  // NOTE: matrix storage and the lane accumulators carry no reset; their
  // contents are only consumed after being written in the current run.
  always_ff @(posedge clk) begin
    if (a_take) a_mem[a_row][a_col] <= a_data;
    if (b_take) b_mem[b_row][b_col] <= b_data;
    if (state == COMPUTE) begin
      for (int j = 0; j < LANES; j++) begin
        acc[j] <= sum[j];
        if (last_k) c_mem[r_idx][lane_col[j]] <= res[j];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_count  <= '0;
      b_count  <= '0;
      acc_en   <= 1'b0;
      c_init   <= 1'b0;
      r_idx    <= '0;
      g_idx    <= '0;
      k_idx    <= '0;
      c_data   <= '0;
      c_row    <= '0;
      c_col    <= '0;
      c_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            acc_en   <= acc_mode & c_init;
            a_count  <= '0;
            b_count  <= '0;
            sat_flag <= 1'b0;
          end
        end
        LOAD: begin
          a_count <= a_count_n;
          b_count <= b_count_n;
          if (a_count_n == ACW'(A_TOT) && b_count_n == BCW'(B_TOT)) begin
            state <= COMPUTE;
            r_idx <= '0;
            g_idx <= '0;
            k_idx <= '0;
          end
        end
        COMPUTE: begin
          if (last_k) begin
            k_idx <= '0;
            if (|clamp) sat_flag <= 1'b1;
            if (g_idx == GW'(GROUPS - 1)) begin
              g_idx <= '0;
              if (r_idx == MW'(M - 1)) begin
                state  <= OUTPUT;
                c_init <= 1'b1;
                c_row  <= '0;
                c_col  <= '0;
              end else begin
                r_idx <= r_idx + MW'(1);
              end
            end else begin
              g_idx <= g_idx + GW'(1);
            end
          end else begin
            k_idx <= k_idx + KW'(1);
          end
        end
        OUTPUT: begin
          if (!c_valid) begin
            // First OUTPUT cycle only primes the output register.
            c_data  <= c_mem[c_row][c_col];
            c_valid <= 1'b1;
          end else if (c_ready) begin
            if (c_row == MW'(M - 1) && c_col == NW'(N - 1)) begin
              c_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              c_row  <= next_row;
              c_col  <= next_col;
              c_data <= c_mem[next_row][next_col];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_matmul_engine.sv
// Bench for lane_matmul_engine with M=N=K=4, LANES=2. Two instances share all
// inputs: dut0 truncates (ROUND=0), dut1 rounds (ROUND=1). Each has its own
// expected-result queue, drained by a monitor on every output handshake.
module tb_lane_matmul_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, acc_mode = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;
  logic [1:0]  a_row = '0, a_col = '0, b_row = '0, b_col = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0, c_ready = 1'b1;

  logic [15:0] c_data0, c_data1;
  logic [1:0]  c_row0, c_col0, c_row1, c_col1;
  logic        c_valid0, c_valid1, busy0, busy1, done0, done1, sat0, sat1;

  always #5 clk = ~clk;

  lane_matmul_engine #(.DATA_WIDTH(16), .FRAC_WIDTH(8), .M(4), .N(4), .K(4),
                       .LANES(2), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
    .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_valid(a_valid),
    .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_valid(b_valid),
    .c_data(c_data0), .c_row(c_row0), .c_col(c_col0), .c_valid(c_valid0),
    .c_ready(c_ready), .busy(busy0), .done(done0), .sat_flag(sat0));

  lane_matmul_engine #(.DATA_WIDTH(16), .FRAC_WIDTH(8), .M(4), .N(4), .K(4),
                       .LANES(2), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
    .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_valid(a_valid),
    .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_valid(b_valid),
    .c_data(c_data1), .c_row(c_row1), .c_col(c_col1), .c_valid(c_valid1),
    .c_ready(c_ready), .busy(busy1), .done(done1), .sat_flag(sat1));

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          n_vec = 0, n_err = 0;
  int          done_cnt = 0;
  logic [15:0] am[4][4], bm[4][4], e0[4][4], e1[4][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for dut0: scoreboard pop on handshake plus stall stability.
  logic        stall0 = 1'b0;
  logic [15:0] h_data;
  logic [1:0]  h_row, h_col;
  always @(negedge clk) begin
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (done0) done_cnt++;
      if (stall0) begin
        chk("stall_valid", c_valid0, 1'b1);
        chk("stall_data", c_data0, h_data);
        chk("stall_idx", {c_row0, c_col0}, {h_row, h_col});
      end
      if (c_valid0 && c_ready) begin
        if (q0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL c0_unexpected: got (%0d,%0d)=%0h, expected no output", c_row0, c_col0, c_data0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("c0_row", c_row0, e.row);
          chk("c0_col", c_col0, e.col);
          chk("c0_data", c_data0, e.data);
        end
      end
      stall0 = c_valid0 && !c_ready;
      h_data = c_data0;
      h_row  = c_row0;
      h_col  = c_col0;
    end
  end

  // Monitor for dut1 (rounding instance): data and index ordering only.
  always @(negedge clk) begin
    if (!rst && c_valid1 && c_ready) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL c1_unexpected: got (%0d,%0d)=%0h, expected no output", c_row1, c_col1, c_data1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("c1_idx", {c_row1, c_col1}, {e.row, e.col});
        chk("c1_data", c_data1, e.data);
      end
    end
  end

  task automatic set_identity(input int scale);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = (i == j) ? 16'h0100 : 16'h0000;
        bm[i][j] = 16'(16 * i + j);
        e0[i][j] = 16'(scale * (16 * i + j));
        e1[i][j] = e0[i][j];
      end
  endtask

  task automatic fill(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        am[i][j] = av;
        bm[i][j] = bv;
        e0[i][j] = ev;
        e1[i][j] = ev;
      end
  endtask

  // One full run. rand_ready: random backpressure. extras: load A first,
  // then B alongside surplus A writes, with a stray start during LOAD.
  // flood: drive A writes throughout OUTPUT.
  task automatic run(input bit acc, input bit rand_ready, input bit extras,
                     input bit flood, input bit exp_sat);
    int cyc;
    int d0;
    d0 = done_cnt;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        q0.push_back('{row: 2'(r), col: 2'(c), data: e0[r][c]});
        q1.push_back('{row: 2'(r), col: 2'(c), data: e1[r][c]});
      end
    acc_mode = acc;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    acc_mode = 1'b0;
    chk("busy_after_start", busy0, 1'b1);
    chk("sat_cleared", sat0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1;
      a_row = 2'(i / 4);
      a_col = 2'(i % 4);
      a_data = am[i / 4][i % 4];
      b_valid = !extras;
      b_row = 2'(i / 4);
      b_col = 2'(i % 4);
      b_data = bm[i / 4][i % 4];
      if (extras && i == 3) begin
        start    = 1'b1;
        acc_mode = 1'b1;
      end
      tick();
      start    = 1'b0;
      acc_mode = 1'b0;
    end
    if (extras) begin
      for (int i = 0; i < 16; i++) begin
        a_valid = 1'b1;
        a_row = 2'(i / 4);
        a_col = 2'(i % 4);
        a_data = 16'h7FFF;
        b_valid = 1'b1;
        b_row = 2'(i / 4);
        b_col = 2'(i % 4);
        b_data = bm[i / 4][i % 4];
        tick();
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc = 0;
    while (!c_valid0 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("compute_latency", cyc, 33);
    cyc = 0;
    while (!done0 && cyc < 500) begin
      c_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (flood) begin
        a_valid = 1'b1;
        a_row = 2'(cyc % 4);
        a_col = 2'(cyc / 4 % 4);
        a_data = 16'h7FFF;
      end
      tick();
      cyc++;
    end
    a_valid = 1'b0;
    c_ready = 1'b1;
    chk("done_seen", done0, 1'b1);
    chk("busy_at_done", busy0, 1'b0);
    chk("valid_at_done", c_valid0, 1'b0);
    chk("sat_flag", sat0, exp_sat);
    tick();
    tick();
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  // Load a run, then hit rst in the middle of COMPUTE.
  task automatic abort_run();
    set_identity(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1;
      a_row = 2'(i / 4);
      a_col = 2'(i % 4);
      a_data = am[i / 4][i % 4];
      b_valid = 1'b1;
      b_row = 2'(i / 4);
      b_col = 2'(i % 4);
      b_data = bm[i / 4][i % 4];
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (5) tick();
    chk("busy_in_compute", busy0, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_busy", busy0, 1'b0);
    chk("abort_valid", c_valid0, 1'b0);
    chk("abort_done", done0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_c_data", c_data0, 16'h0);
    chk("rst_c_idx", {c_row0, c_col0}, 4'h0);
    chk("rst_c_valid", c_valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_sat", sat0, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy0, 1'b0);

    // Identity, fresh C: acc_mode requested but c_init is clear -> C = B.
    set_identity(1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Same operands accumulated onto stored C, with A writes during OUTPUT.
    set_identity(2);
    run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // rst during COMPUTE clears c_init, so acc_mode=1 yields plain B.
    abort_run();
    set_identity(1);
    run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Backpressure, surplus A writes, stray start during LOAD.
    set_identity(1);
    run(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Rounding: 1 * 0x80 -> 0.5 LSB; -1 * 0x80 -> -0.5 LSB.
    fill(16'h0, 16'h0, 16'h0);
    am[0][0] = 16'h0001;
    bm[0][0] = 16'h0080;
    e0[0][0] = 16'h0000;
    e1[0][0] = 16'h0001;
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(16'h0, 16'h0, 16'h0);
    am[0][0] = 16'hFFFF;
    bm[0][0] = 16'h0080;
    e0[0][0] = 16'hFFFF;
    e1[0][0] = 16'h0000;
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation at both rails; the following start must clear sat_flag.
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(16'h8000, 16'h7FFF, 16'h8000);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_identity(1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
